melody_sequencer: RTL and testbench

Sequences a short programmable melody into the `piano_keyboard` tone generator by driving its 8-bit one-hot `key` input. It arbitrates that input between live player keys and stored playback; live keys always win. It sits between the board switches/buttons and `piano_keyboard`, in the 50 MHz `clk` domain.

---
 rtl/piano_pkg.sv | 30 +++
 rtl/melody_sequencer_if.sv | 32 +++
 rtl/melody_sequencer_beat_timer.sv | 40 ++++
 rtl/melody_sequencer.sv | 133 +++++++++++++
 tb/tb_melody_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// Shared types and constants for the melody sequencer that feeds
// the piano_keyboard tone generator.
package piano_pkg;

    localparam int CLK_HZ = 50_000_000;

    localparam logic [2:0] NOTE_C  = 3'd0;
    localparam logic [2:0] NOTE_D  = 3'd1;
    localparam logic [2:0] NOTE_E  = 3'd2;
    localparam logic [2:0] NOTE_F  = 3'd3;
    localparam logic [2:0] NOTE_G  = 3'd4;
    localparam logic [2:0] NOTE_A  = 3'd5;
    localparam logic [2:0] NOTE_B  = 3'd6;
    localparam logic [2:0] NOTE_C2 = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic       last;
        logic [2:0] note;
        logic       rest;
        logic [2:0] beats_m1;
    } step_t;

endpackage

// File: rtl/melody_sequencer_if.sv
// Control, programming and key-output bundle between the board
// controls and the melody sequencer.
interface melody_sequencer_if #(
    parameter int NUM_STEPS = 16
);
    localparam int AW = $clog2(NUM_STEPS);

    logic          start;
    logic          stop;
    logic          loop;
    logic [7:0]    key_live;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [7:0]    key_out;
    logic          busy;
    logic [AW-1:0] step_idx;
    logic          done;

    modport master (
        output start, stop, loop, key_live,
        output prog_we, prog_addr, prog_data,
        input  key_out, busy, step_idx, done
    );

    modport slave (
        input  start, stop, loop, key_live,
        input  prog_we, prog_addr, prog_data,
        output key_out, busy, step_idx, done
    );

endinterface

// File: rtl/melody_sequencer_beat_timer.sv
// Beat timer: a BEAT_DIV prescaler feeding a beat down-counter,
// pulsing expire in the last cycle of the loaded duration.
module beat_timer #(
    parameter int BEAT_DIV = 6_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] beats,
    input  logic       en,
    output logic       expire
);
    localparam int PW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_beats;
    logic          w_tick;

    assign w_tick = en && (r_presc == PW'(BEAT_DIV - 1));
    assign expire = w_tick && (r_beats == 3'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= '0;
            r_beats <= '0;
        end else if (load) begin
            r_presc <= '0;
            r_beats <= beats;
        end else if (en) begin
            if (w_tick) begin
                r_presc <= '0;
                if (r_beats != 3'd0)
                    r_beats <= r_beats - 3'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Stored-melody player driving piano_keyboard.key; live player
// keys always win the output and pause playback while held.
module melody_sequencer
    import piano_pkg::*;
#(
    parameter int NUM_STEPS = 16,
    parameter int BEAT_DIV  = 6_250_000,
    parameter int GAP_DIV   = 500_000
) (
    input logic               clk,
    input logic               rst,
    melody_sequencer_if.slave bus
);
    localparam int AW = $clog2(NUM_STEPS);
    localparam int GW = (GAP_DIV > 1) ? $clog2(GAP_DIV) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_STEPS - 1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nx;
    step_t         r_mem [NUM_STEPS];
    logic [GW-1:0] r_gap;
    logic [7:0]    r_key;
    logic [7:0]    w_key_nx;
    logic [7:0]    w_live_low;
    logic [2:0]    w_beats;
    logic          w_live;
    logic          w_run;
    logic          w_busy;
    logic          w_load;
    logic          w_beat_exp;
    logic          w_gap_exp;

    assign w_live     = |bus.key_live;
    assign w_run      = !w_live;
    assign w_live_low = bus.key_live & (~bus.key_live + 8'd1);
    assign w_busy     = (r_state == S_PLAY) || (r_state == S_GAP);
    assign w_gap_exp  = (r_state == S_GAP) && w_run
                        && (r_gap == GW'(GAP_DIV - 1));
    assign w_beats    = bus.stop ? 3'd0 : r_mem[w_idx_nx].beats_m1;

    beat_timer #(
        .BEAT_DIV(BEAT_DIV)
    ) u_beat (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load | bus.stop),
        .beats (w_beats),
        .en    ((r_state == S_PLAY) && w_run),
        .expire(w_beat_exp)
    );

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_load     = 1'b0;
        if (bus.stop) begin
            w_state_nx = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (bus.start) begin
                    w_state_nx = S_PLAY;
                    w_idx_nx   = '0;
                    w_load     = 1'b1;
                end
                S_PLAY: if (w_beat_exp) w_state_nx = S_GAP;
                S_GAP: if (w_gap_exp) begin
                    if (r_mem[r_idx].last || r_idx == LAST_IDX) begin
                        if (bus.loop) begin
                            w_state_nx = S_PLAY;
                            w_idx_nx   = '0;
                            w_load     = 1'b1;
                        end else begin
                            w_state_nx = S_DONE;
                        end
                    end else begin
                        w_state_nx = S_PLAY;
                        w_idx_nx   = r_idx + AW'(1);
                        w_load     = 1'b1;
                    end
                end
                S_DONE: w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Decided from the next state so the note lines up with PLAY.
    always_comb begin
        w_key_nx = '0;
        if (w_live)
            w_key_nx = w_live_low;
        else if (w_state_nx == S_PLAY && !r_mem[w_idx_nx].rest)
            w_key_nx = 8'h01 << r_mem[w_idx_nx].note;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_key   <= w_key_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_gap <= '0;
        else if (bus.stop || r_state != S_GAP)
            r_gap <= '0;
        else if (w_run)
            r_gap <= w_gap_exp ? '0 : r_gap + GW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_STEPS; i++)
                r_mem[i] <= '0;
        end else if (bus.prog_we && !w_busy) begin
            r_mem[bus.prog_addr] <= step_t'(bus.prog_data);
        end
    end

    assign bus.key_out  = r_key;
    assign bus.busy     = w_busy;
    assign bus.step_idx = r_idx;
    assign bus.done     = (r_state == S_DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: idle arbitration table, directed
// playback sequences and random stimulus against a trace model.
module tb_melody_sequencer;
    localparam int NS = 4;
    localparam int BD = 4;
    localparam int GD = 2;
    localparam int AW = $clog2(NS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    melody_sequencer_if #(.NUM_STEPS(NS)) bus ();

    melody_sequencer #(
        .NUM_STEPS(NS),
        .BEAT_DIV (BD),
        .GAP_DIV  (GD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0]    key;
        logic [AW-1:0] idx;
    } ent_t;

    typedef struct {
        logic [7:0] live;
        logic [7:0] key;
    } vec_t;

    int errs = 0;
    int checks = 0;

    // Model: a flat per-cycle trace of one pass; position -1 is idle,
    // position == trace size is the done cycle.
    logic [7:0] m_mem [NS];
    ent_t       m_tr [$];
    int         m_pos = -1;
    logic [7:0] m_key = '0;

    function automatic logic m_busy();
        return (m_pos >= 0) && (m_pos < m_tr.size());
    endfunction

    function automatic logic m_done();
        return m_pos == m_tr.size();
    endfunction

    function automatic logic [7:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return 8'(1 << i);
        return 8'h00;
    endfunction

    function automatic void build();
        logic [7:0] w;
        int len;
        m_tr.delete();
        for (int s = 0; s < NS; s++) begin
            w = m_mem[s];
            len = (int'(w[2:0]) + 1) * BD;
            for (int c = 0; c < len; c++)
                m_tr.push_back('{key: (w[3] ? 8'h00 : 8'(1 << w[6:4])),
                                 idx: AW'(s)});
            for (int c = 0; c < GD; c++)
                m_tr.push_back('{key: 8'h00, idx: AW'(s)});
            if (w[7]) break;
        end
    endfunction

    function automatic void model_step();
        logic bsy;
        if (!rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_pos = -1;
            m_key = '0;
            return;
        end
        bsy = m_busy();
        if (bus.stop) begin
            m_pos = -1;
        end else if (m_pos < 0) begin
            if (bus.start) begin
                build();
                m_pos = 0;
            end
        end else if (m_pos == m_tr.size()) begin
            m_pos = -1;
        end else if (bus.key_live == 8'h00) begin
            if (m_pos == m_tr.size() - 1)
                m_pos = bus.loop ? 0 : m_tr.size();
            else
                m_pos++;
        end
        if (bus.prog_we && !bsy)
            m_mem[bus.prog_addr] = bus.prog_data;
        if (bus.key_live != 8'h00)
            m_key = lowest(bus.key_live);
        else if (m_busy())
            m_key = m_tr[m_pos].key;
        else
            m_key = '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("key_out", 32'(bus.key_out), 32'(m_key));
        chk("busy", 32'(bus.busy), 32'(m_busy()));
        chk("done", 32'(bus.done), 32'(m_done()));
        if (m_busy())
            chk("step_idx", 32'(bus.step_idx), 32'(m_tr[m_pos].idx));
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        bus.key_live = '0;
        bus.prog_we = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
    endtask

    task automatic prog(input logic [AW-1:0] a, input logic [7:0] d);
        bus.prog_we = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick();
        bus.prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    vec_t vecs [8];
    int n;
    int nz;
    int hold;

    initial begin
        vecs[0] = '{8'h00, 8'h00};
        vecs[1] = '{8'h28, 8'h08};
        vecs[2] = '{8'h80, 8'h80};
        vecs[3] = '{8'hFF, 8'h01};
        vecs[4] = '{8'h06, 8'h02};
        vecs[5] = '{8'h40, 8'h40};
        vecs[6] = '{8'h0C, 8'h04};
        vecs[7] = '{8'h00, 8'h00};

        idle_inputs();
        rst = 1'b0;
        tick();
        chk("rst_key", 32'(bus.key_out), 32'h0);
        chk("rst_idx", 32'(bus.step_idx), 32'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            bus.key_live = vecs[i].live;
            tick();
            chk("arb", 32'(bus.key_out), 32'(vecs[i].key));
        end
        bus.key_live = '0;

        // Basic playback
        prog(AW'(0), 8'h00);
        prog(AW'(1), 8'h91);
        pulse_start();
        chk("basic_first", 32'(bus.key_out), 32'h01);
        wait_done(100, n);
        chk("basic_len", 32'(n), 32'd16);
        tick();
        chk("basic_done_once", 32'(bus.done), 32'h0);
        chk("basic_idle", 32'(bus.busy), 32'h0);

        // Loop, then drop loop in the second pass
        bus.loop = 1'b1;
        pulse_start();
        repeat (16) tick();
        chk("loop_idx", 32'(bus.step_idx), 32'h0);
        chk("loop_key", 32'(bus.key_out), 32'h01);
        chk("loop_nodone", 32'(bus.done), 32'h0);
        repeat (4) tick();
        bus.loop = 1'b0;
        wait_done(100, n);
        chk("loop_len", 32'(20 + n), 32'd32);
        tick();

        // Live override pauses step 0
        pulse_start();
        repeat (2) tick();
        bus.key_live = 8'h28;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("live_key", 32'(bus.key_out), 32'h08);
        end
        bus.key_live = '0;
        wait_done(100, n);
        chk("live_len", 32'(12 + n), 32'd26);
        tick();

        // Stop, start+stop, write lock
        pulse_start();
        repeat (3) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_busy", 32'(bus.busy), 32'h0);
        chk("stop_key", 32'(bus.key_out), 32'h0);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick();
        idle_inputs();
        chk("startstop_busy", 32'(bus.busy), 32'h0);
        pulse_start();
        prog(AW'(0), 8'h70);
        wait_done(100, n);
        tick();
        pulse_start();
        chk("wlock_key", 32'(bus.key_out), 32'h01);
        wait_done(100, n);
        tick();

        // Rest step and index wrap
        prog(AW'(0), 8'h0B);
        prog(AW'(1), 8'h20);
        prog(AW'(2), 8'h30);
        prog(AW'(3), 8'h40);
        pulse_start();
        nz = (bus.key_out != 8'h00) ? 1 : 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (bus.key_out != 8'h00) nz++;
        end
        chk("rest_zero", 32'(nz), 32'd0);
        wait_done(100, n);
        chk("wrap_len", 32'(17 + n), 32'd36);
        tick();

        // Random stimulus against the trace model
        for (int r = 0; r < 12; r++) begin
            idle_inputs();
            for (int a = 0; a < NS; a++)
                prog(AW'(a), 8'($urandom_range(0, 255)));
            pulse_start();
            hold = 0;
            for (int c = 0; c < 300 && m_pos >= 0; c++) begin
                if (hold > 0) begin
                    hold--;
                end else begin
                    bus.key_live = '0;
                    if ($urandom_range(0, 11) == 0) begin
                        hold = $urandom_range(1, 5);
                        bus.key_live = 8'($urandom_range(1, 255));
                    end
                end
                bus.loop = ($urandom_range(0, 3) == 0);
                bus.stop = ($urandom_range(0, 149) == 0);
                bus.start = ($urandom_range(0, 19) == 0);
                bus.prog_we = !bus.start && ($urandom_range(0, 9) == 0);
                bus.prog_addr = AW'($urandom_range(0, NS - 1));
                bus.prog_data = 8'($urandom_range(0, 255));
                tick();
            end
            idle_inputs();
            bus.stop = 1'b1;
            tick();
            bus.stop = 1'b0;
            tick();
        end

        // Reset mid-PLAY clears storage
        idle_inputs();
        prog(AW'(0), 8'h91);
        pulse_start();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_key", 32'(bus.key_out), 32'h0);
        chk("mrst_busy", 32'(bus.busy), 32'h0);
        chk("mrst_idx", 32'(bus.step_idx), 32'h0);
        chk("mrst_done", 32'(bus.done), 32'h0);
        pulse_start();
        chk("mrst_first", 32'(bus.key_out), 32'h01);
        wait_done(100, n);
        chk("mrst_len", 32'(n), 32'd24);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
